// File: rtl/seq_mult_issue_ctrl.sv
// Operand-pair FIFO feeding a sequential multiplier one op at a time; products leave on valid/ready.
// Optional WAIT watchdog is enabled by defining MUL_TIMEOUT_EN.
module seq_mult_issue_ctrl #(
    parameter int WIDTH          = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_a,
    input  logic [WIDTH-1:0]            in_b,
    output logic                        mul_start,
    output logic [WIDTH-1:0]            mul_multiplicand,
    output logic [WIDTH-1:0]            mul_multiplier,
    input  logic [2*WIDTH-1:0]          mul_product,
    input  logic                        mul_done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2*WIDTH-1:0]          out_product,
    output logic                        out_err,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [2*WIDTH-1:0]     mem_r [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_r;
    logic [PW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   mul_start_r;
    logic [WIDTH-1:0]       op_a_r;
    logic [WIDTH-1:0]       op_b_r;
    logic                   out_valid_r;
    logic [2*WIDTH-1:0]     out_product_r;
    logic                   full_s;
    logic                   empty_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   timeout_hit_s;

    // in_ready looks only at full, so a pop never opens a same-cycle slot
    assign full_s  = (count_r == CNT_FULL);
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = in_valid && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;

    assign in_ready         = !full_s;
    assign fifo_count       = count_r;
    assign busy             = (state_r != ST_IDLE) || !empty_s;
    assign mul_start        = mul_start_r;
    assign mul_multiplicand = op_a_r;
    assign mul_multiplier   = op_b_r;
    assign out_valid        = out_valid_r;
    assign out_product      = out_product_r;

`ifdef MUL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1'b1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_r;
    logic          out_err_r;

    assign timeout_hit_s = (state_r == ST_WAIT) && !mul_done && (timer_r == TMR_LAST);
    assign out_err       = out_err_r;

    // WAIT-cycle counter, restarted by every issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_r <= {TW{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            timer_r <= {TW{1'b0}};
        end else if ((state_r == ST_WAIT) && !mul_done && !timeout_hit_s) begin
            timer_r <= timer_r + TMR_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    // error flag travels with the product it qualifies
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_err_r <= 1'b0;
        end else if ((state_r == ST_WAIT) && mul_done) begin
            out_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            out_err_r <= 1'b1;
        end else if ((state_r == ST_OUT) && out_ready) begin
            out_err_r <= 1'b0;
        end else begin
            out_err_r <= out_err_r;
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign out_err       = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state: done seen in ISSUE may be left over from the previous op, so only WAIT honours it
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (mul_done || timeout_hit_s) state_s = ST_OUT;
                else                           state_s = ST_WAIT;
            end
            ST_OUT: begin
                if (out_ready) state_s = ST_IDLE;
                else           state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {(2*WIDTH){1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {in_a, in_b};
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            rd_ptr_r <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // operand registers and start pulse, both loaded by the IDLE pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            mul_start_r <= 1'b0;
        end else begin
            mul_start_r <= pop_s;
            if (pop_s) begin
                op_a_r <= mem_r[rd_ptr_r][2*WIDTH-1:WIDTH];
                op_b_r <= mem_r[rd_ptr_r][WIDTH-1:0];
            end else begin
                op_a_r <= op_a_r;
                op_b_r <= op_b_r;
            end
        end
    end

    // product capture; out_product keeps its value after the handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_r   <= 1'b0;
            out_product_r <= {(2*WIDTH){1'b0}};
        end else if ((state_r == ST_WAIT) && mul_done) begin
            out_valid_r   <= 1'b1;
            out_product_r <= mul_product;
        end else if (timeout_hit_s) begin
            out_valid_r   <= 1'b1;
            out_product_r <= {(2*WIDTH){1'b0}};
        end else if ((state_r == ST_OUT) && out_ready) begin
            out_valid_r   <= 1'b0;
            out_product_r <= out_product_r;
        end else begin
            out_valid_r   <= out_valid_r;
            out_product_r <= out_product_r;
        end
    end

endmodule
